// File: rtl/edge_serializer.sv
// Fast-clock parallel-to-serial gearbox: loads a word on each aligner edge pulse,
// shifts it out LSB-first in SW-bit slices and tracks the edge period for lock.
module edge_serializer #(
  parameter int unsigned PW       = 8,
  parameter int unsigned SW       = 2,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          firstedge,
  input  logic [PW-1:0] din,
  input  logic          valid_in,
  output logic [SW-1:0] dout,
  output logic          dout_valid,
  output logic          frame,
  output logic          locked,
  output logic          error
);

  localparam int unsigned R    = PW / SW;
  localparam int unsigned PH_W = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned LC_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   sreg;
  logic            vld;
  logic [PH_W-1:0] phase;
  logic [LC_W-1:0] lock_cnt;
  logic            on_time;

  // Last slice of the word is on dout: an edge now is on time, no edge is a wrap.
  assign on_time    = (phase == PH_W'(R - 1));
  assign dout       = sreg[SW-1:0];
  assign dout_valid = vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sreg     <= '0;
      vld      <= 1'b0;
      phase    <= '0;
      lock_cnt <= '0;
      frame    <= 1'b0;
      locked   <= 1'b0;
      error    <= 1'b0;
    end else begin
      error <= 1'b0;
      if (firstedge) begin
        // Load wins over shift; any unsent slices of the old word are dropped.
        sreg  <= din;
        vld   <= valid_in;
        phase <= '0;
        frame <= 1'b1;
        case (state)
          IDLE: begin
            state    <= TRACK;
            lock_cnt <= '0;
          end
          TRACK: begin
            if (on_time) begin
              if (lock_cnt == LC_W'(LOCK_CNT - 1)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                lock_cnt <= LC_W'(LOCK_CNT);
              end else begin
                lock_cnt <= lock_cnt + LC_W'(1);
              end
            end else begin
              error    <= 1'b1;
              lock_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!on_time) begin
              error    <= 1'b1;
              state    <= TRACK;
              locked   <= 1'b0;
              lock_cnt <= '0;
            end
          end
          default: begin
            state    <= IDLE;
            locked   <= 1'b0;
            lock_cnt <= '0;
          end
        endcase
      end else begin
        sreg  <= sreg >> SW;
        frame <= 1'b0;
        if (on_time) begin
          // Wrap with no new edge: the word is exhausted and the edge went missing.
          phase <= '0;
          vld   <= 1'b0;
          if (state != IDLE) begin
            error    <= 1'b1;
            state    <= IDLE;
            locked   <= 1'b0;
            lock_cnt <= '0;
          end
        end else begin
          phase <= phase + PH_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_serializer.sv
// Bench for edge_serializer: vector table for the nominal lock-up, directed corner
// sequences, and random edges checked against a cycle-age reference model.
module tb_edge_serializer;

  localparam int PW = 8;
  localparam int SW = 2;
  localparam int R  = PW / SW;
  localparam int LC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fe, valid_in;
  logic [7:0]  din;
  logic [1:0]  dout;
  logic        dout_valid, frame, locked, error;

  logic        fe2, valid2;
  logic [15:0] din2;
  logic [3:0]  dout2;
  logic        dv2, fr2, lk2, er2;

  int errors = 0;
  int checks = 0;

  edge_serializer #(.PW(8), .SW(2), .LOCK_CNT(4)) dut (
    .clk(clk), .reset(reset), .firstedge(fe), .din(din), .valid_in(valid_in),
    .dout(dout), .dout_valid(dout_valid), .frame(frame), .locked(locked), .error(error)
  );

  edge_serializer #(.PW(16), .SW(4), .LOCK_CNT(1)) dut_b (
    .clk(clk), .reset(reset), .firstedge(fe2), .din(din2), .valid_in(valid2),
    .dout(dout2), .dout_valid(dv2), .frame(fr2), .locked(lk2), .error(er2)
  );

  always #5 clk = ~clk;

  // Reference model: age = cycles since last load (or reset); mode 0 idle, 1 track, 2 locked.
  int         m_age, m_mode, m_run;
  logic [7:0] m_word;
  logic       m_wv, m_fr, m_er;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_age = 0; m_mode = 0; m_run = 0;
    m_word = 8'h00; m_wv = 1'b0; m_fr = 1'b0; m_er = 1'b0;
  endtask

  task automatic model_step(input logic f, input logic [7:0] d, input logic v);
    bit on_t;
    on_t = ((m_age % R) == R - 1);
    m_er = 1'b0;
    m_fr = f;
    if (f) begin
      if (m_mode == 0) begin
        m_mode = 1; m_run = 0;
      end else if (!on_t) begin
        m_er = 1'b1; m_mode = 1; m_run = 0;
      end else if (m_mode == 1) begin
        m_run++;
        if (m_run == LC) m_mode = 2;
      end
      m_word = d; m_wv = v; m_age = 0;
    end else begin
      if (on_t && m_mode != 0) begin
        m_er = 1'b1; m_mode = 0; m_run = 0;
      end
      m_age++;
    end
  endtask

  function automatic int m_dout();
    logic [7:0] t;
    if (m_age >= R) return 0;
    t = m_word >> (SW * m_age);
    return int'(t[1:0]);
  endfunction

  task automatic cycle(input logic f, input logic [7:0] d, input logic v);
    fe = f; din = d; valid_in = v;
    @(posedge clk);
    model_step(f, d, v);
    #1;
    check("dout",       int'(dout),       m_dout());
    check("dout_valid", int'(dout_valid), int'(m_wv && m_age < R));
    check("frame",      int'(frame),      int'(m_fr));
    check("locked",     int'(locked),     int'(m_mode == 2));
    check("error",      int'(error),      int'(m_er));
  endtask

  task automatic cycle_b(input logic f, input logic [15:0] d);
    fe2 = f; din2 = d; valid2 = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    logic       f;
    logic [7:0] d;
    logic       v;
    logic [1:0] e_dout;
    logic       e_fr, e_lk, e_er;
  } vec_t;

  vec_t tbl[17];
  logic [1:0] b4_slices [4];

  initial begin
    b4_slices[0] = 2'd0; b4_slices[1] = 2'd1; b4_slices[2] = 2'd3; b4_slices[3] = 2'd2;
    for (int i = 0; i < 17; i++) begin
      tbl[i].f      = ((i % 4) == 0);
      tbl[i].d      = 8'hB4;
      tbl[i].v      = 1'b1;
      tbl[i].e_dout = b4_slices[i % 4];
      tbl[i].e_fr   = ((i % 4) == 0);
      tbl[i].e_lk   = (i == 16);
      tbl[i].e_er   = 1'b0;
    end

    fe = 0; din = 0; valid_in = 0; fe2 = 0; din2 = 0; valid2 = 0;
    reset = 1'b1;
    model_reset();
    #12;
    check("reset_dout",   int'(dout), 0);
    check("reset_valid",  int'(dout_valid), 0);
    check("reset_locked", int'(locked), 0);
    @(negedge clk);
    reset = 1'b0;

    // Wide instance: PW=16, SW=4, lock after one on-time edge.
    cycle_b(1'b1, 16'h1234);
    check("b_slice0", int'(dout2), 4); check("b_frame0", int'(fr2), 1); check("b_dv", int'(dv2), 1);
    cycle_b(1'b0, 16'h0); check("b_slice1", int'(dout2), 3);
    cycle_b(1'b0, 16'h0); check("b_slice2", int'(dout2), 2);
    cycle_b(1'b0, 16'h0); check("b_slice3", int'(dout2), 1); check("b_lock_pre", int'(lk2), 0);
    cycle_b(1'b1, 16'h1234);
    check("b_lock", int'(lk2), 1); check("b_err", int'(er2), 0); check("b_reload", int'(dout2), 4);
    fe2 = 1'b0;

    // Nominal lock-up from the table.
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].f, tbl[i].d, tbl[i].v);
      check($sformatf("tbl%0d_dout", i),  int'(dout),   int'(tbl[i].e_dout));
      check($sformatf("tbl%0d_frame", i), int'(frame),  int'(tbl[i].e_fr));
      check($sformatf("tbl%0d_lock", i),  int'(locked), int'(tbl[i].e_lk));
      check($sformatf("tbl%0d_err", i),   int'(error),  int'(tbl[i].e_er));
      check($sformatf("tbl%0d_dv", i),    int'(dout_valid), 1);
    end

    // Early edge at phase 1 while locked.
    cycle(1'b0, 8'hB4, 1'b1);
    cycle(1'b1, 8'hB4, 1'b1);
    check("early_err", int'(error), 1); check("early_lock", int'(locked), 0);
    check("early_frame", int'(frame), 1); check("early_slice0", int'(dout), 0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) cycle(1'b0, 8'hB4, 1'b1);
      check("early_err_once", int'(error), 0);
      cycle(1'b1, 8'hB4, 1'b1);
      check("relock", int'(locked), int'(k == 3));
    end

    // Missing edge while locked.
    for (int j = 0; j < 3; j++) cycle(1'b0, 8'hB4, 1'b1);
    cycle(1'b0, 8'hB4, 1'b1);
    check("miss_err", int'(error), 1); check("miss_lock", int'(locked), 0);
    check("miss_dv", int'(dout_valid), 0); check("miss_dout", int'(dout), 0);
    cycle(1'b1, 8'hB4, 1'b1);
    check("restart_err", int'(error), 0); check("restart_frame", int'(frame), 1);

    // Relock, then an invalid all-ones word.
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) cycle(1'b0, 8'hB4, 1'b1);
      cycle(1'b1, 8'hB4, 1'b1);
    end
    check("lock_before_inv", int'(locked), 1);
    for (int j = 0; j < 3; j++) cycle(1'b0, 8'hB4, 1'b1);
    cycle(1'b1, 8'hFF, 1'b0);
    for (int j = 0; j < 4; j++) begin
      check("inv_dout", int'(dout), 3); check("inv_dv", int'(dout_valid), 0);
      check("inv_lock", int'(locked), 1);
      if (j < 3) cycle(1'b0, 8'h00, 1'b0);
    end
    cycle(1'b1, 8'hB4, 1'b1);
    check("valid_back", int'(dout_valid), 1); check("valid_back_lock", int'(locked), 1);

    // Random edges, biased toward the nominal period.
    for (int n = 0; n < 3000; n++) begin
      logic f;
      if ((m_age % R) == R - 1) f = (($urandom % 8) != 0);
      else                     f = (($urandom % 12) == 0);
      cycle(f, 8'($urandom), (($urandom % 4) != 0));
    end

    // Asynchronous reset in the middle of a word.
    cycle(1'b1, 8'hB4, 1'b1);
    cycle(1'b0, 8'hB4, 1'b1);
    fe = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_dout", int'(dout), 0);   check("async_dv", int'(dout_valid), 0);
    check("async_frame", int'(frame), 0); check("async_lock", int'(locked), 0);
    check("async_err", int'(error), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int j = 0; j < 6; j++) begin
      cycle(1'b0, 8'hFF, 1'b1);
      check("post_reset_quiet", int'({dout, dout_valid, frame, locked, error}), 0);
    end
    cycle(1'b1, 8'hB4, 1'b1);
    check("post_reset_frame", int'(frame), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edge_serializer.md
# edge_serializer

Fast-clock parallel-to-serial gearbox placed directly downstream of the slow/fast clock edge aligner. Runs entirely on the fast clock. It uses the aligner's one-cycle `firstedge` pulse to capture a parallel word from the slow domain, then emits that word in SW-bit slices, LSB first, one slice per fast cycle. It also tracks whether `firstedge` arrives with the expected period, and reports lock status and alignment errors.

## Interface
- PW, 8: parallel word width; must be an integer multiple of SW.
- SW, 2: serial slice width. R = PW/SW slices per word; R ≥ 2.
- LOCK_CNT, 4: consecutive on-time edges required to assert `locked`; ≥ 1.

Ports:
- clk  input  1  fast clock; same clock as the aligner's fast clock.
- reset  input  1  asynchronous, active-high reset.
- firstedge  input  1  one-cycle pulse from the edge aligner; marks the load point.
- din  input  PW  parallel word from the slow domain; stable whenever `firstedge` = 1.
- valid_in  input  1  slow-domain qualifier for `din`; sampled together with `din`.
- dout  output  SW  current slice.
- dout_valid  output  1  `dout` carries a slice of a valid word.
- frame  output  1  `dout` is slice 0 of a word.
- locked  output  1  edge period is stable.
- error  output  1  one-cycle pulse on a misaligned or missing edge.

## Operation
Internal state:
- PW-bit shift register `sreg`; `dout` = `sreg[SW-1:0]`.
- valid flag `vld`.
- phase counter, 0..R-1.
- lock counter, 0..LOCK_CNT.
- state machine: IDLE, TRACK, LOCKED.

Load (any state, `firstedge` = 1):
- `sreg` <= `din`.
- `vld` <= `valid_in`.
- phase <= 0.
- `frame` <= 1.

Shift (no `firstedge`):
- `sreg` <= `sreg` >> SW, zero fill.
- phase <= phase+1, wrapping R-1 -> 0.
- `frame` <= 0.
- When phase wraps without a load, `vld` <= 0.

`dout_valid` = `vld`. It is independent of `locked`.

On-time edge: `firstedge` = 1 while phase == R-1.

State machine:
- **IDLE.**
  - `firstedge` -> TRACK, lock counter <= 0.
  - A wrap with no edge causes no error.
- **TRACK.**
  - On-time edge -> lock counter +1. If the new value equals LOCK_CNT, go to LOCKED.
  - Early edge (phase != R-1) -> `error`, lock counter <= 0, stay in TRACK. The load still happens.
  - Missing edge (phase == R-1, no `firstedge`) -> `error`, go to IDLE.
- **LOCKED.**
  - On-time edge -> stay in LOCKED.
  - Early edge -> `error`, go to TRACK, lock counter <= 0. The load still happens.
  - Missing edge -> `error`, go to IDLE.
- `locked` = 1 exactly when state == LOCKED; it is registered.

## Timing
- Reset values: `sreg` = 0, `dout` = 0, `dout_valid` = 0, `frame` = 0, `locked` = 0, `error` = 0, phase = 0, lock counter = 0, state IDLE.
- Reset mid-word: all of the above apply immediately, because reset is asynchronous. The first `firstedge` after reset release restarts operation from IDLE.
- Latency: `firstedge` at cycle t -> slice 0 on `dout` with `frame` = 1 at t+1. Slice k appears at t+1+k. Nominal edge period is R cycles.
- `error` and `locked` update in the cycle after the triggering edge or wrap. `error` is high for exactly one cycle.
- Back-to-back `firstedge` (period 1) is an early edge every cycle: each one reloads and raises `error` (except from IDLE).
- `valid_in` = 0 at load: slices are still shifted out, with `dout_valid` = 0 for those R cycles.
- A load overrides shift in the same cycle. The previous word's unsent slices are discarded.

## Test plan
- **Reset:** assert reset asynchronously mid-word (PW=8, SW=2) -> all outputs 0 within the same cycle. After release, no activity until `firstedge`.
- **Nominal:** `din` = 0xB4, `valid_in` = 1, `firstedge` at t0 and every 4 cycles thereafter -> `dout` reads 0,1,3,2 per word. `frame` is high on the 0 slice. `dout_valid` stays 1. `locked` rises at t0+17, i.e. after the 4th on-time edge at t0+16.
- **Early edge:** while locked, pulse `firstedge` at phase 1 -> `error` is 1 for one cycle. `locked` falls the next cycle. The new word starts at slice 0. Lock is regained after 4 further on-time edges.
- **Missing edge:** while locked, omit one `firstedge` -> at the wrap, `error` pulses, `locked` falls, `dout_valid` falls, `dout` = 0. The next edge restarts TRACK with no error.
- **Invalid word:** `valid_in` = 0 with `din` = 0xFF -> `dout` = 3,3,3,3 with `dout_valid` = 0. The following valid word restores `dout_valid` = 1. `locked` is unaffected.
- **Parameter sweep:** PW=16, SW=4, LOCK_CNT=1, `din` = 0x1234 -> `dout` = 4,3,2,1. `locked` asserts one cycle after the second edge.
